// File: rtl/targ_fb_queue_pkg.sv
// Shared types for the target-feedback queue: lane resolutions, predictor feedback and
// queue entry layout.
package targ_fb_queue_pkg;

  localparam int unsigned peval_width = 4;
  localparam int unsigned addr_width  = 32;
  localparam int unsigned k_width     = $clog2(peval_width + 1);

  typedef logic [addr_width-1:0] addr_t;
  typedef logic [k_width-1:0]    k_t;

  typedef struct packed {
    logic  valid;
    addr_t base_pc;
    addr_t targ_addr;
  } targ_res_t;

  typedef struct packed {
    logic  valid;
    addr_t base_pc;
    addr_t targ_addr;
  } targ_pred_fb_t;

  typedef struct packed {
    addr_t base_pc;
    addr_t targ_addr;
  } entry_t;

endpackage

// File: rtl/targ_fb_queue_if.sv
// Resolution-in / feedback-out bundle between the parallel-evaluation lanes and the queue.
interface targ_fb_queue_if;
  import targ_fb_queue_pkg::*;

  logic                                en;
  targ_res_t     [peval_width-1:0]     res;
  logic                                ready;
  targ_pred_fb_t                       fb;

  modport master (output en, res, input ready, fb);
  modport slave  (input en, res, output ready, fb);

endinterface

// File: rtl/targ_fb_compact.sv
// Drops lanes duplicating an earlier valid lane, then packs survivors into the low slots.
module targ_fb_compact
  import targ_fb_queue_pkg::*;
(
  input  targ_res_t [peval_width-1:0] res_i,
  output targ_res_t [peval_width-1:0] surv_o,
  output k_t                          k_o
);

  logic [peval_width-1:0] dup;

  always_comb begin
    dup    = '0;
    surv_o = '0;
    k_o    = '0;
    for (int i = 0; i < peval_width; i++) begin
      for (int j = 0; j < i; j++) begin
        if (res_i[j].valid && res_i[i].valid &&
            res_i[j].base_pc == res_i[i].base_pc &&
            res_i[j].targ_addr == res_i[i].targ_addr) begin
          dup[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < peval_width; i++) begin
      if (res_i[i].valid && !dup[i]) begin
        surv_o[k_o] = res_i[i];
        k_o         = k_o + k_t'(1);
      end
    end
  end

endmodule

// File: rtl/targ_fb_queue.sv
// Serialises merged lane resolutions into one registered predictor feedback per cycle;
// overflow drops and counts rather than stalling.
module targ_fb_queue
  import targ_fb_queue_pkg::*;
#(
  parameter int unsigned depth     = 16,
  parameter int unsigned cnt_width = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  targ_fb_queue_if.slave               bus,
  output logic [$clog2(depth+1)-1:0]   occupancy,
  output logic [cnt_width-1:0]         drop_cnt
);

  typedef logic [$clog2(depth)-1:0]   idx_t;
  typedef logic [$clog2(depth+1)-1:0] occ_t;

  targ_res_t [peval_width-1:0] surv;
  k_t                          k;

  entry_t        mem_q [depth];
  idx_t          head_q, head_d, tail_q, tail_d;
  occ_t          occ_q, occ_d, remaining;
  logic          ready_q, ready_d;
  targ_pred_fb_t fb_q, fb_d;
  logic [cnt_width-1:0] drop_q, drop_d;
  logic [cnt_width:0]   drop_sum;
  logic          push, pop;

  targ_fb_compact u_compact (
    .res_i  (bus.res),
    .surv_o (surv),
    .k_o    (k)
  );

  always_comb begin
    pop       = bus.en && fb_q.valid;
    push      = ready_q && (k != '0);
    head_d    = pop ? head_q + idx_t'(1) : head_q;
    tail_d    = push ? tail_q + idx_t'(k) : tail_q;
    remaining = pop ? occ_q - occ_t'(1) : occ_q;
    occ_d     = push ? remaining + occ_t'(k) : remaining;
    ready_d   = occ_d <= occ_t'(depth - peval_width);

    drop_sum = {1'b0, drop_q} + (cnt_width + 1)'(k);
    drop_d   = drop_q;
    if (!ready_q && k != '0) begin
      drop_d = drop_sum[cnt_width] ? '1 : drop_sum[cnt_width-1:0];
    end

    // Head slot is being written this very edge when the queue would otherwise be empty.
    fb_d = '0;
    if (occ_d != '0) begin
      fb_d.valid = 1'b1;
      if (remaining == '0) begin
        fb_d.base_pc   = surv[0].base_pc;
        fb_d.targ_addr = surv[0].targ_addr;
      end else begin
        fb_d.base_pc   = mem_q[head_d].base_pc;
        fb_d.targ_addr = mem_q[head_d].targ_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < peval_width; i++) begin
      if (ready_q && surv[i].valid) begin
        mem_q[tail_q + idx_t'(i)] <= '{base_pc: surv[i].base_pc, targ_addr: surv[i].targ_addr};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      ready_q <= 1'b1;
      fb_q    <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
      fb_q    <= fb_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.fb    = fb_q;
  assign occupancy = occ_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_targ_fb_queue.sv
// Directed bench for targ_fb_queue at depth 8, four lanes.
module tb_targ_fb_queue;
  import targ_fb_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  occupancy;
  logic [15:0] drop_cnt;
  targ_res_t [peval_width-1:0] ref_surv;
  k_t          ref_k;
  int          n_vec = 0;
  int          n_err = 0;

  targ_fb_queue_if bus ();

  targ_fb_queue #(.depth(8), .cnt_width(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  targ_fb_compact u_ref (
    .res_i  (bus.res),
    .surv_o (ref_surv),
    .k_o    (ref_k)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] tg);
    bus.res[l] = '{valid: 1'b1, base_pc: pc, targ_addr: tg};
  endtask

  task automatic chk_fb(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] tg);
    chk({tag, ".valid"}, 64'(bus.fb.valid), 64'(v));
    chk({tag, ".pc"},    64'(bus.fb.base_pc), 64'(pc));
    chk({tag, ".targ"},  64'(bus.fb.targ_addr), 64'(tg));
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.res = '0;
    #12;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk_fb("rst_fb", 1'b0, 32'h0, 32'h0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    step();
    rst = 1'b0;

    // Single lane, one-cycle latency, then consumed.
    bus.en = 1'b1;
    set_lane(0, 32'h100, 32'h200);
    step();
    bus.res = '0;
    chk_fb("single", 1'b1, 32'h100, 32'h200);
    chk("single_occ1", 64'(occupancy), 64'd1);
    step();
    chk("single_gone", 64'(bus.fb.valid), 64'd0);
    chk("single_occ0", 64'(occupancy), 64'd0);

    // Four distinct lanes held with en low, then drained in lane order.
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 32'h10 + 32'(i), 32'h1000 + 32'(i));
    step();
    bus.res = '0;
    step();
    step();
    chk("four_occ", 64'(occupancy), 64'd4);
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_fb("four_drain", 1'b1, 32'h10 + 32'(i), 32'h1000 + 32'(i));
      step();
    end
    chk("four_empty", 64'(bus.fb.valid), 64'd0);

    // Duplicate merge: lane 2 duplicates lane 0.
    bus.en = 1'b0;
    set_lane(0, 32'h40, 32'h80);
    set_lane(1, 32'h40, 32'h90);
    set_lane(2, 32'h40, 32'h80);
    #1;
    chk("merge_ref_k", 64'(ref_k), 64'd2);
    step();
    bus.res = '0;
    chk("merge_occ", 64'(occupancy), 64'd2);
    chk_fb("merge_0", 1'b1, 32'h40, 32'h80);
    bus.en = 1'b1;
    step();
    chk_fb("merge_1", 1'b1, 32'h40, 32'h90);
    step();
    chk("merge_occ0", 64'(occupancy), 64'd0);

    // Overflow: two bursts fill, third is dropped and counted.
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 32'h20 + 32'(i), 32'h3000 + 32'(i));
    step();
    chk("ovf_ready_mid", 64'(bus.ready), 64'd1);
    for (int i = 0; i < 4; i++) set_lane(i, 32'h24 + 32'(i), 32'h3004 + 32'(i));
    step();
    chk("ovf_occ8", 64'(occupancy), 64'd8);
    chk("ovf_ready0", 64'(bus.ready), 64'd0);
    for (int i = 0; i < 4; i++) set_lane(i, 32'h30 + 32'(i), 32'h4000 + 32'(i));
    step();
    bus.res = '0;
    chk("ovf_drop", 64'(drop_cnt), 64'd4);
    chk("ovf_occ_held", 64'(occupancy), 64'd8);
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_fb("ovf_drain", 1'b1, 32'h20 + 32'(i), 32'h3000 + 32'(i));
      step();
    end
    chk("ovf_empty", 64'(bus.fb.valid), 64'd0);

    // Steady push/pop across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      set_lane(0, 32'h500 + 32'(i), 32'h600 + 32'(i));
      step();
      chk("wrap_pc", 64'(bus.fb.base_pc), 64'(32'h500 + 32'(i)));
      chk("wrap_occ", 64'(occupancy), 64'd1);
    end
    bus.res = '0;
    step();
    chk("wrap_empty", 64'(bus.fb.valid), 64'd0);

    // Asynchronous reset with five entries queued.
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 32'h50 + 32'(i), 32'h60 + 32'(i));
    step();
    bus.res = '0;
    set_lane(0, 32'h54, 32'h64);
    step();
    bus.res = '0;
    chk("arst_pre_occ", 64'(occupancy), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.fb.valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    #1;
    rst = 1'b0;
    set_lane(0, 32'h700, 32'h800);
    step();
    bus.res = '0;
    chk_fb("arst_push", 1'b1, 32'h700, 32'h800);
    chk("arst_push_occ", 64'(occupancy), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/targ_fb_queue.md
# targ_fb_queue

Buffers resolved target outcomes from the parallel-evaluation lanes and serialises them into the single per-cycle feedback port of the target predictor. It sits directly upstream of `targ_pred`: up to `core::peval_width` resolutions arrive per cycle, duplicates within a cycle are merged, and one `core::targ_pred_fb_t` is presented per cycle in arrival order. Feedback is loss-tolerant, so overflow drops entries and counts them rather than stalling resolution.

## Interface
- `depth`, 16, queue entries; power of two, `>= 2*core::peval_width`
- `cnt_width`, 16, width of the saturating drop counter
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous and active-high
- `en`  in  1  pipeline enable; gates dequeue only
- `res[core::peval_width]`  in  `core::targ_res_t` each  resolution per lane: `valid`, `base_pc` (`sys::addr_t`), `targ_addr` (`sys::addr_t`)
- `ready`  out  1  high when free slots `>= core::peval_width`; registered
- `fb`  out  `core::targ_pred_fb_t`  head entry: `valid`, `base_pc`, `targ_addr`; registered
- `occupancy`  out  `$clog2(depth+1)`  entries held
- `drop_cnt`  out  `cnt_width`  saturating count of dropped resolutions

## Operation
- Merge step (combinational): a valid lane `i` is discarded if any lane `j < i` is valid with an identical (`base_pc`, `targ_addr`). Survivors are compacted in ascending lane order. The count `k` ranges 0..`peval_width`.
- Push:
  - If `ready` is high, all `k` survivors are written at `tail..tail+k-1` (mod `depth`), and `tail += k`.
  - If `ready` is low, nothing is written and `drop_cnt += k`, saturating at all-ones.
  - Pushes are accepted regardless of `en`.
- Pop: when `en && fb.valid` at a clock edge, the head is consumed and `head += 1`.
- `occupancy_next = occupancy + (pushed ? k : 0) - (popped ? 1 : 0)`.
- `ready_next = (depth - occupancy_next) >= peval_width`. This is conservative: a same-cycle pop never raises `ready` within that cycle.
- `fb` is the head entry. `fb.valid = (occupancy != 0)`. When `fb.valid` is low, the `base_pc`/`targ_addr` fields are `'0`.
- Pointers are `$clog2(depth)` bits and wrap naturally. The full/empty distinction comes from `occupancy`, not from pointer equality.
- No deduplication against entries already queued; `targ_pred` tolerates repeated feedback.
- Reset values:
  - `head = tail = 0`, `occupancy = 0`
  - `fb = '0`, `ready = 1`, `drop_cnt = 0`
  - storage contents are don't-care
- Reset mid-operation discards all queued entries immediately, with no drain.

## Timing
- Resolution at edge N is visible on `fb` after edge N (one cycle latency) if the queue was empty.
- Back-to-back pops are supported: one entry per enabled cycle.
- Simultaneous push and pop on an empty queue:
  - the pop is not possible (`fb.valid` = 0);
  - the pushed head appears the next cycle.
- Simultaneous push and pop at `occupancy == depth - peval_width`:
  - `ready` was high, so the push is accepted;
  - `ready_next` is computed from the resulting occupancy.
- With `en` low, `fb` holds steady and occupancy only grows.
- `rst` asserts `fb.valid` low asynchronously, without waiting for `clk`.

## Structure
- `core::targ_res_t` belongs in the `core` package next to `core::targ_pred_fb_t`. Its fields are `valid`, `base_pc`, `targ_addr`.
- Local typedefs: queue index and occupancy widths.
- Sub-module `targ_fb_compact`, combinational: takes `res[]` and produces the compacted survivor array plus `k`. It is reused by the bench as a reference model.
- Storage is a register array. Writes go to `peval_width` ports at offsets from `tail`. Read is at `head`, registered into `fb`.

## Test plan
All scenarios use `peval_width = 4`, `depth = 8`.
- Single lane 0 (`pc=0x100`, `targ=0x200`) at cycle 0, `en=1` -> `fb` = {1, `0x100`, `0x200`} at cycle 1; `fb.valid` = 0 at cycle 2; `occupancy` 0.
- All 4 lanes valid with distinct `pc` `0x10..0x13`, `en=0` for 3 cycles, then `en=1` -> `fb` emits `0x10`, `0x11`, `0x12`, `0x13` on consecutive cycles after enable.
- Lanes 0, 2 = (`0x40`, `0x80`) and lane 1 = (`0x40`, `0x90`) -> 2 entries queued, order (`0x40`,`0x80`), (`0x40`,`0x90`); `occupancy` = 2.
- `en=0`, 4-lane bursts on consecutive cycles:
  - after 2 bursts (`occupancy` 8), `ready` = 0;
  - the third burst gives `drop_cnt` = 4 and `occupancy` stays 8;
  - the queue drains 8 entries in original order.
- Wrap: push/pop steady state for 20 cycles with 1 entry per cycle -> every `base_pc` is returned in order; `occupancy` is never above 1.
- Assert `rst` mid-cycle with `occupancy` 5 -> `fb.valid`, `occupancy` and `drop_cnt` go to 0 before the next edge; the first push after release appears at `fb` one cycle later.
